phase_sequencer: RTL and testbench



---
 rtl/phase_sequencer_if.sv | 33 +++
 rtl/phase_sequencer.sv | 115 +++++++++++
 tb/tb_phase_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Control-phase bundle between the phase sequencer and its host/decoder.
// Run/step/stall/opcode in; strobes, status and debug counters out.
interface phase_sequencer_if #(
    parameter int CYCLE_W = 32,
    parameter int INSTR_W = 16
);
    logic               run;
    logic               step;
    logic               stall;
    logic [4:0]         opcode;
    logic               extra1;
    logic               fe;
    logic               e1;
    logic               e2;
    logic               retire;
    logic               halted;
    logic               fault;
    logic [2:0]         phase;
    logic [CYCLE_W-1:0] cycle_count;
    logic [INSTR_W-1:0] instr_count;

    modport master (
        output run, step, stall, opcode, extra1,
        input  fe, e1, e2, retire, halted, fault,
        input  phase, cycle_count, instr_count
    );

    modport slave (
        input  run, step, stall, opcode, extra1,
        output fe, e1, e2, retire, halted, fault,
        output phase, cycle_count, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Phase generator ahead of the decoder: one-hot fe/e1/e2 strobes,
// run/single-step control, STP halt, fetch-stall watchdog, debug counters.
module phase_sequencer #(
    parameter int CYCLE_W     = 32,
    parameter int INSTR_W     = 16,
    parameter int STALL_LIMIT = 15
) (
    input logic              clock,
    input logic              n_reset,
    phase_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC1 = 3'd2,
        EXEC2 = 3'd3,
        HALT  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    state_t             state;
    state_t             nxt;
    state_t             end_nxt;
    logic               step_flag;
    logic [7:0]         stall_cnt;
    logic               stp;
    logic               retire;
    logic               active;
    logic               fe_q;
    logic               e1_q;
    logic               e2_q;
    logic               halted_q;
    logic               fault_q;
    logic [CYCLE_W-1:0] cyc_q;
    logic [INSTR_W-1:0] ins_q;

    assign stp    = (bus.opcode == 5'd0);
    assign retire = (state == EXEC1 && !bus.extra1 && !stp)
                 || (state == EXEC2);
    assign active = (state == FETCH) || (state == EXEC1)
                 || (state == EXEC2);

    // A stepped instruction always stops; a run stops once run drops.
    assign end_nxt = (step_flag || !bus.run) ? IDLE : FETCH;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (bus.run || bus.step) nxt = FETCH;
            FETCH: begin
                if (!bus.stall)              nxt = EXEC1;
                else if (stall_cnt == LIMIT) nxt = FAULT;
            end
            EXEC1: begin
                if (stp)             nxt = HALT;
                else if (bus.extra1) nxt = EXEC2;
                else                 nxt = end_nxt;
            end
            EXEC2:   nxt = end_nxt;
            HALT:    nxt = HALT;
            FAULT:   nxt = FAULT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state     <= IDLE;
            step_flag <= 1'b0;
            stall_cnt <= 8'd0;
            cyc_q     <= '0;
            ins_q     <= '0;
            fe_q      <= 1'b0;
            e1_q      <= 1'b0;
            e2_q      <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state    <= nxt;
            fe_q     <= (nxt == FETCH);
            e1_q     <= (nxt == EXEC1);
            e2_q     <= (nxt == EXEC2);
            halted_q <= (nxt == HALT);
            fault_q  <= (nxt == FAULT);

            if (state == IDLE)
                step_flag <= !bus.run && bus.step;
            else if (retire && nxt == IDLE)
                step_flag <= 1'b0;

            // Bounded by LIMIT: the watchdog fires before it can wrap.
            if (state == FETCH && bus.stall)
                stall_cnt <= stall_cnt + 8'd1;
            else
                stall_cnt <= 8'd0;

            if (active && cyc_q != '1)
                cyc_q <= cyc_q + 1'b1;
            if (retire && ins_q != '1)
                ins_q <= ins_q + 1'b1;
        end
    end

    assign bus.fe          = fe_q;
    assign bus.e1          = e1_q;
    assign bus.e2          = e2_q;
    assign bus.retire      = retire;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.phase       = state;
    assign bus.cycle_count = cyc_q;
    assign bus.instr_count = ins_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: directed rows push expectations,
// a negedge monitor pops and compares against both DUT configurations.
module tb_phase_sequencer;
    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       stall = 1'b0;
    logic [4:0] opcode = 5'd0;
    logic       extra1 = 1'b0;

    int checks = 0;
    int failures = 0;
    int row = 0;

    typedef struct {
        int          row;
        bit          sel;
        logic [2:0]  ph;
        logic        ret;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    phase_sequencer_if #(.CYCLE_W(32), .INSTR_W(16)) ifa ();
    phase_sequencer_if #(.CYCLE_W(4),  .INSTR_W(4))  ifb ();

    assign ifa.run    = run;
    assign ifa.step   = step;
    assign ifa.stall  = stall;
    assign ifa.opcode = opcode;
    assign ifa.extra1 = extra1;
    assign ifb.run    = run;
    assign ifb.step   = step;
    assign ifb.stall  = stall;
    assign ifb.opcode = opcode;
    assign ifb.extra1 = extra1;

    phase_sequencer #(
        .CYCLE_W(32), .INSTR_W(16), .STALL_LIMIT(15)
    ) dut_a (
        .clock(clk), .n_reset(n_reset), .bus(ifa)
    );

    phase_sequencer #(
        .CYCLE_W(4), .INSTR_W(4), .STALL_LIMIT(4)
    ) dut_b (
        .clock(clk), .n_reset(n_reset), .bus(ifb)
    );

    task automatic check(input string name, input int r, input bit s,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d dut=%0d got=%0d exp=%0d",
                     name, r, s, got, exp);
        end
    endtask

    // Inputs for one cycle plus the outputs expected during that cycle.
    task automatic drv(input bit sel, input bit chk, input logic rst,
                       input logic r, input logic s, input logic st,
                       input logic [4:0] op, input logic ex,
                       input int ph, input int ret,
                       input int cy, input int in);
        exp_t e;
        @(posedge clk);
        #1;
        n_reset = rst;
        run     = r;
        step    = s;
        stall   = st;
        opcode  = op;
        extra1  = ex;
        if (chk) begin
            e.row = row;
            e.sel = sel;
            e.ph  = 3'(ph);
            e.ret = ret[0];
            e.cyc = 32'(cy);
            e.ins = 32'(in);
            q.push_back(e);
        end
        row++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [2:0]  ph;
        logic [31:0] cy;
        logic [31:0] in;
        logic [4:0]  fl;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.sel) begin
                ph = ifb.phase;
                cy = 32'(ifb.cycle_count);
                in = 32'(ifb.instr_count);
                fl = {ifb.fe, ifb.e1, ifb.e2, ifb.halted, ifb.fault};
                check("retire", e.row, e.sel, 32'(ifb.retire), 32'(e.ret));
            end else begin
                ph = ifa.phase;
                cy = ifa.cycle_count;
                in = 32'(ifa.instr_count);
                fl = {ifa.fe, ifa.e1, ifa.e2, ifa.halted, ifa.fault};
                check("retire", e.row, e.sel, 32'(ifa.retire), 32'(e.ret));
            end
            check("phase", e.row, e.sel, 32'(ph), 32'(e.ph));
            check("fe", e.row, e.sel, 32'(fl[4]), 32'(e.ph == 3'd1));
            check("e1", e.row, e.sel, 32'(fl[3]), 32'(e.ph == 3'd2));
            check("e2", e.row, e.sel, 32'(fl[2]), 32'(e.ph == 3'd3));
            check("halted", e.row, e.sel, 32'(fl[1]), 32'(e.ph == 3'd4));
            check("fault", e.row, e.sel, 32'(fl[0]), 32'(e.ph == 3'd5));
            check("cycle_count", e.row, e.sel, cy, e.cyc);
            check("instr_count", e.row, e.sel, in, e.ins);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout row=%0d", row);
        $fatal(1);
    end

    initial begin
        // reset state
        drv(0, 1, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0);
        // free run, single-phase instructions
        drv(0, 1, 1, 1, 0, 0, 5'd1,  0, 0, 0, 0, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd1,  0, 1, 0, 0, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd1,  0, 2, 1, 1, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd1,  0, 1, 0, 2, 1);
        drv(0, 1, 1, 1, 0, 0, 5'd1,  0, 2, 1, 3, 1);
        drv(0, 1, 1, 1, 0, 0, 5'd1,  0, 1, 0, 4, 2);
        drv(0, 1, 1, 0, 0, 0, 5'd1,  0, 2, 1, 5, 2);
        drv(0, 1, 1, 0, 0, 0, 5'd1,  0, 0, 0, 6, 3);
        drv(0, 1, 0, 0, 0, 0, 5'd1,  0, 0, 0, 6, 3);
        // two-phase LDR instructions
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 0, 0, 0, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 1, 0, 0, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 2, 0, 1, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 3, 1, 2, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 1, 0, 3, 1);
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 2, 0, 4, 1);
        drv(0, 1, 1, 0, 0, 0, 5'd14, 1, 3, 1, 5, 1);
        drv(0, 1, 1, 0, 0, 0, 5'd1,  0, 0, 0, 6, 2);
        // single step; second pulse in EXEC1 ignored
        drv(0, 1, 1, 0, 1, 0, 5'd1,  0, 0, 0, 6, 2);
        drv(0, 1, 1, 0, 0, 0, 5'd1,  0, 1, 0, 6, 2);
        drv(0, 1, 1, 0, 1, 0, 5'd1,  0, 2, 1, 7, 2);
        drv(0, 1, 1, 0, 0, 0, 5'd1,  0, 0, 0, 8, 3);
        drv(0, 1, 1, 0, 0, 0, 5'd1,  0, 0, 0, 8, 3);
        // stepped fetch with 3 stall cycles
        drv(0, 1, 1, 0, 1, 0, 5'd1,  0, 0, 0, 8, 3);
        drv(0, 1, 1, 0, 0, 1, 5'd1,  0, 1, 0, 8, 3);
        drv(0, 1, 1, 0, 0, 1, 5'd1,  0, 1, 0, 9, 3);
        drv(0, 1, 1, 0, 0, 1, 5'd1,  0, 1, 0, 10, 3);
        drv(0, 1, 1, 0, 0, 0, 5'd1,  0, 1, 0, 11, 3);
        drv(0, 1, 1, 0, 0, 1, 5'd1,  0, 2, 1, 12, 3);
        drv(0, 1, 1, 0, 0, 0, 5'd1,  0, 0, 0, 13, 4);
        // STP halts; run/step ignored; reset clears
        drv(0, 1, 1, 1, 0, 0, 5'd1,  0, 0, 0, 13, 4);
        drv(0, 1, 1, 1, 0, 0, 5'd0,  0, 1, 0, 13, 4);
        drv(0, 1, 1, 1, 0, 0, 5'd0,  1, 2, 0, 14, 4);
        drv(0, 1, 1, 0, 0, 0, 5'd0,  0, 4, 0, 15, 4);
        drv(0, 1, 1, 1, 1, 0, 5'd0,  0, 4, 0, 15, 4);
        drv(0, 1, 0, 1, 0, 0, 5'd0,  0, 4, 0, 15, 4);
        drv(0, 1, 1, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0);
        // reset during EXEC2
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 0, 0, 0, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 1, 0, 0, 0);
        drv(0, 1, 1, 1, 0, 0, 5'd14, 1, 2, 0, 1, 0);
        drv(0, 1, 0, 1, 0, 0, 5'd14, 1, 3, 1, 2, 0);
        drv(0, 1, 1, 0, 0, 0, 5'd14, 1, 0, 0, 0, 0);
        // small config: watchdog at STALL_LIMIT=4
        drv(1, 0, 0, 0, 0, 0, 5'd1,  0, 0, 0, 0, 0);
        drv(1, 1, 1, 0, 1, 0, 5'd1,  0, 0, 0, 0, 0);
        drv(1, 1, 1, 0, 0, 1, 5'd1,  0, 1, 0, 0, 0);
        drv(1, 1, 1, 0, 0, 1, 5'd1,  0, 1, 0, 1, 0);
        drv(1, 1, 1, 0, 0, 1, 5'd1,  0, 1, 0, 2, 0);
        drv(1, 1, 1, 0, 0, 1, 5'd1,  0, 1, 0, 3, 0);
        drv(1, 1, 1, 0, 0, 1, 5'd1,  0, 1, 0, 4, 0);
        drv(1, 1, 1, 1, 1, 0, 5'd1,  0, 5, 0, 5, 0);
        drv(1, 1, 1, 1, 0, 0, 5'd1,  0, 5, 0, 5, 0);
        drv(1, 1, 0, 0, 0, 0, 5'd1,  0, 5, 0, 5, 0);
        // 4-bit counters saturate at 15
        drv(1, 1, 1, 1, 0, 0, 5'd1,  0, 0, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            int cy;
            int in;
            cy = (k - 1 > 15) ? 15 : k - 1;
            in = ((k - 1) / 2 > 15) ? 15 : (k - 1) / 2;
            drv(1, 1, 1, 1, 0, 0, 5'd1, 0,
                (k % 2 == 1) ? 1 : 2, (k % 2 == 0) ? 1 : 0, cy, in);
        end
        drv(1, 0, 1, 0, 0, 0, 5'd1,  0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
